// File: rtl/rms_pkg.sv
// Shared types and helpers for the RMS square-root datapath.
package rms_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int ROUND_FLOOR   = 0;
  localparam int ROUND_NEAREST = 1;

  function automatic int sqrt_rw(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/rms_sqrt_seq_sqrt_step.sv
// One restoring digit-by-digit square-root iteration, purely combinational.
module sqrt_step #(
  parameter int RW = 8
) (
  input  logic [RW+1:0] rem,
  input  logic [RW-1:0] q,
  input  logic [1:0]    top2,
  output logic [RW+1:0] rem_next,
  output logic [RW-1:0] q_next
);

  localparam int RMW = RW + 2;
  localparam int EXW = RW + 4;

  logic [EXW-1:0] rt;
  logic [EXW-1:0] trial;
  logic [EXW-1:0] diff;
  logic           take;

  // Working at RW+4 bits keeps the shifted remainder and trial value exact.
  assign rt    = {rem, top2};
  assign trial = {2'b00, q, 2'b01};
  assign diff  = rt - trial;
  assign take  = (rt >= trial);

  assign rem_next = take ? RMW'(diff) : RMW'(rt);
  assign q_next   = RW'({q, take});

endmodule

// File: rtl/rms_sqrt_seq.sv
// Sequential integer square root: one root bit per clock, floor or nearest result.
module rms_sqrt_seq
  import rms_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ROUND = ROUND_FLOOR
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             radicand,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [sqrt_rw(WIDTH)-1:0]    root,
  output logic [sqrt_rw(WIDTH):0]      remainder,
  output logic                         rounded_up,
  output logic                         saturated
);

  localparam int RW   = sqrt_rw(WIDTH);
  localparam int REMW = RW + 1;
  localparam int RMW  = RW + 2;
  localparam int CW   = $clog2(RW + 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("rms_sqrt_seq: WIDTH must be even and >= 4");
  end
  if (ROUND != ROUND_FLOOR && ROUND != ROUND_NEAREST) begin : g_bad_round
    $error("rms_sqrt_seq: ROUND must be 0 or 1");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  x_q, x_d;
  logic [RW-1:0]     q_q, q_d;
  logic [RMW-1:0]    rem_q, rem_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     root_q, root_d;
  logic [REMW-1:0]   remainder_q, remainder_d;
  logic              rounded_up_q, rounded_up_d;
  logic              saturated_q, saturated_d;

  logic [RMW-1:0]    rem_next;
  logic [RW-1:0]     q_next;
  logic              want_up;
  logic              q_at_max;

  sqrt_step #(.RW(RW)) u_step (
    .rem      (rem_q),
    .q        (q_q),
    .top2     (x_q[WIDTH-1 -: 2]),
    .rem_next (rem_next),
    .q_next   (q_next)
  );

  // Nearest rounding: sqrt(n) >= q+0.5 exactly when the floor remainder exceeds q.
  assign want_up  = (ROUND == ROUND_NEAREST) && (rem_next > {2'b00, q_next});
  assign q_at_max = &q_next;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d      = state_q;
    x_d          = x_q;
    q_d          = q_q;
    rem_d        = rem_q;
    cnt_d        = cnt_q;
    root_d       = root_q;
    remainder_d  = remainder_q;
    rounded_up_d = rounded_up_q;
    saturated_d  = saturated_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = radicand;
          q_d     = '0;
          rem_d   = '0;
          cnt_d   = CW'(RW);
          state_d = CALC;
        end
      end

      CALC: begin
        x_d   = x_q << 2;
        q_d   = q_next;
        rem_d = rem_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d      = DONE;
          remainder_d  = REMW'(rem_next);
          rounded_up_d = want_up && !q_at_max;
          saturated_d  = want_up && q_at_max;
          root_d       = (want_up && !q_at_max) ? q_next + RW'(1) : q_next;
        end
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      q_q          <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      root_q       <= '0;
      remainder_q  <= '0;
      rounded_up_q <= 1'b0;
      saturated_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      x_q          <= x_d;
      q_q          <= q_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
      root_q       <= root_d;
      remainder_q  <= remainder_d;
      rounded_up_q <= rounded_up_d;
      saturated_q  <= saturated_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign root       = root_q;
  assign remainder  = remainder_q;
  assign rounded_up = rounded_up_q;
  assign saturated  = saturated_q;

endmodule

// File: tb/tb_rms_sqrt_seq.sv
// Bench for rms_sqrt_seq: six instances (WIDTH 16/8/24 x ROUND 0/1) with a scoreboard.
module tb_rms_sqrt_seq;

  localparam int N_DUT = 6;

  typedef struct {
    logic [11:0] root;
    logic [12:0] rem;
    logic        ru;
    logic        sat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N_DUT-1:0]  in_valid;
  logic [N_DUT-1:0]  out_ready;
  logic [N_DUT-1:0]  in_ready;
  logic [N_DUT-1:0]  out_valid;
  logic [N_DUT-1:0]  rounded_up;
  logic [N_DUT-1:0]  saturated;
  logic [23:0]       radicand;
  logic [11:0]       root_a [N_DUT];
  logic [12:0]       rem_a  [N_DUT];

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    localparam int W = (g < 2) ? 16 : ((g < 4) ? 8 : 24);
    logic [W/2-1:0] r;
    logic [W/2:0]   m;
    rms_sqrt_seq #(.WIDTH(W), .ROUND(g % 2)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .radicand   (radicand[W-1:0]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .root       (r),
      .remainder  (m),
      .rounded_up (rounded_up[g]),
      .saturated  (saturated[g])
    );
    assign root_a[g] = 12'(r);
    assign rem_a[g]  = 13'(m);
  end

  function automatic int width_of(input int idx);
    return (idx < 2) ? 16 : ((idx < 4) ? 8 : 24);
  endfunction

  // Reference: greedy bitwise floor root, then a squared test for nearest rounding.
  function automatic exp_t model(input int idx, input logic [23:0] n);
    exp_t    e;
    int      rw;
    longint  r, t, nn, rem;
    bit      up;
    rw = width_of(idx) / 2;
    nn = longint'(n);
    r  = 0;
    for (int b = rw - 1; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= nn) r = t;
    end
    rem   = nn - r * r;
    up    = ((idx % 2) == 1) && ((2 * r + 1) * (2 * r + 1) <= 4 * nn);
    e.sat = up && (r == (longint'(1) << rw) - 1);
    e.ru  = up && !e.sat;
    e.root = 12'(e.ru ? r + 1 : r);
    e.rem  = 13'(rem);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input string tag, input exp_t e);
    check($sformatf("%s_root[%0d]", tag, idx), 32'(root_a[idx]), 32'(e.root));
    check($sformatf("%s_rem[%0d]", tag, idx), 32'(rem_a[idx]), 32'(e.rem));
    check($sformatf("%s_ru[%0d]", tag, idx), 32'(rounded_up[idx]), 32'(e.ru));
    check($sformatf("%s_sat[%0d]", tag, idx), 32'(saturated[idx]), 32'(e.sat));
  endtask

  // One transaction: accept, bounded wait for out_valid, optional stall, consume.
  task automatic do_op(input int idx, input logic [23:0] n, input int stall, input bit poke);
    int   rw;
    int   cyc;
    exp_t ex;
    rw = width_of(idx) / 2;
    check($sformatf("ready_before[%0d]", idx), 32'(in_ready[idx]), 32'd1);
    radicand      = n;
    in_valid[idx] = 1'b1;
    sb.push_back(model(idx, n));
    @(negedge clk);
    in_valid[idx] = 1'b0;
    check($sformatf("busy_ready[%0d]", idx), 32'(in_ready[idx]), 32'd0);
    cyc = 0;
    while (!out_valid[idx] && cyc < 100) begin
      if (poke && cyc == 3) begin
        in_valid[idx] = 1'b1;
        radicand      = ~n;
      end else begin
        in_valid[idx] = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid[idx] = 1'b0;
    check($sformatf("latency[%0d]", idx), 32'(cyc), 32'(rw));
    ex = sb.pop_front();
    for (int s = 0; s < stall; s++) begin
      check($sformatf("stall_valid[%0d]", idx), 32'(out_valid[idx]), 32'd1);
      check($sformatf("stall_ready[%0d]", idx), 32'(in_ready[idx]), 32'd0);
      check_outputs(idx, "stall", ex);
      in_valid[idx] = poke && (s == 1);
      radicand      = 24'h00ABCD;
      @(negedge clk);
    end
    in_valid[idx] = 1'b0;
    check_outputs(idx, "result", ex);
    out_ready[idx] = 1'b1;
    @(negedge clk);
    out_ready[idx] = 1'b0;
    check($sformatf("post_valid[%0d]", idx), 32'(out_valid[idx]), 32'd0);
    check($sformatf("post_ready[%0d]", idx), 32'(in_ready[idx]), 32'd1);
  endtask

  initial begin
    exp_t zero_e;
    zero_e    = '{root: 12'd0, rem: 13'd0, ru: 1'b0, sat: 1'b0};
    in_valid  = '0;
    out_ready = '0;
    radicand  = '0;

    // Reset state while rst is held.
    #1;
    check("reset_in_ready", 32'(in_ready), 32'h3F);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check_outputs(0, "reset", zero_e);
    check_outputs(5, "reset", zero_e);
    @(negedge clk);
    rst = 1'b0;

    // Floor mode, WIDTH=16.
    do_op(0, 24'd144, 0, 1'b0);
    do_op(0, 24'd0, 0, 1'b0);
    do_op(0, 24'd65535, 0, 1'b0);
    // Nearest mode, WIDTH=16.
    do_op(1, 24'd156, 0, 1'b0);
    do_op(1, 24'd157, 0, 1'b0);
    do_op(1, 24'd65535, 0, 1'b0);
    do_op(1, 24'd0, 0, 1'b0);
    // Backpressure with ignored in_valid pulses in CALC and DONE.
    do_op(0, 24'd40000, 5, 1'b1);
    do_op(1, 24'd65280, 5, 1'b1);

    // Reset in the middle of CALC discards the operation.
    radicand    = 24'd12345;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_out_valid", 32'(out_valid[0]), 32'd0);
    check("midreset_in_ready", 32'(in_ready[0]), 32'd1);
    check_outputs(0, "midreset", zero_e);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("discarded_valid", 32'(out_valid[0]), 32'd0);
    do_op(0, 24'd10000, 0, 1'b0);

    // Boundary and random sweep on every width/rounding combination.
    for (int idx = 0; idx < N_DUT; idx++) begin
      logic [23:0] mask;
      mask = 24'((longint'(1) << width_of(idx)) - 1);
      do_op(idx, mask, 1, 1'b0);
      do_op(idx, 24'd0, 0, 1'b0);
      do_op(idx, 24'd3, 0, 1'b0);
      for (int k = 0; k < 14; k++) begin
        do_op(idx, 24'($urandom) & mask, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
